// File: rtl/secuenciador_pkg.sv
// Shared codes, sweep/state enums and step-to-code mapping for the data-block sequencer.
package secuenciador_pkg;

  localparam int unsigned COD_W  = 4;
  localparam int unsigned PASO_W = 4;

  localparam logic [COD_W-1:0] COD_INIT   = 4'd0;
  localparam logic [COD_W-1:0] COD_MS     = 4'd1;
  localparam logic [COD_W-1:0] COD_TRANSF = 4'd2;
  localparam logic [COD_W-1:0] COD_FECHA0 = 4'd3;
  localparam logic [COD_W-1:0] COD_HORA0  = 4'd6;
  localparam logic [COD_W-1:0] COD_CRONO0 = 4'd9;
  localparam logic [COD_W-1:0] COD_IDLE   = 4'd15;

  typedef enum logic [1:0] {BARR_INIT, BARR_LECT, BARR_ESCR} barrido_e;
  typedef enum logic [1:0] {IDLE, EMITIR, ESPERAR} estado_e;

  typedef struct packed {
    logic [COD_W-1:0] codigo;
    logic             rw;
  } paso_t;

  // Code and direction for step idx of a sweep; a write sweep ends with the transfer command.
  function automatic paso_t codigo_paso(input barrido_e b, input logic [1:0] grp,
                                        input logic [PASO_W-1:0] idx);
    paso_t            p;
    logic [COD_W-1:0] base;
    base = (grp == 2'b00) ? COD_FECHA0 : (grp == 2'b01) ? COD_HORA0 : COD_CRONO0;
    p.rw = (b != BARR_LECT);
    case (b)
      BARR_INIT: p.codigo = COD_INIT + idx;
      BARR_LECT: p.codigo = COD_FECHA0 + idx;
      default:   p.codigo = (idx == PASO_W'(3)) ? COD_TRANSF : base + idx;
    endcase
    return p;
  endfunction

  function automatic logic es_ultimo(input barrido_e b, input logic [PASO_W-1:0] idx);
    logic r;
    case (b)
      BARR_INIT: r = (idx == PASO_W'(2));
      BARR_LECT: r = (idx == PASO_W'(8));
      default:   r = (idx == PASO_W'(3));
    endcase
    return r;
  endfunction

endpackage

// File: rtl/secuenciador_bloques_datos_if.sv
// Request, bus-handshake and decoder-code signals of the data-block sequencer.
interface secuenciador_bloques_datos_if;
  logic       init_req;
  logic       escribir_req;
  logic [1:0] grupo_escritura;
  logic       done_bus;
  logic       start_bus;
  logic       rw;
  logic [3:0] Selec_Mux_DD;
  logic       ocupado;
  logic       fin_barrido;
  logic       error_timeout;

  modport master (
    input  init_req, escribir_req, grupo_escritura, done_bus,
    output start_bus, rw, Selec_Mux_DD, ocupado, fin_barrido, error_timeout
  );

  modport slave (
    output init_req, escribir_req, grupo_escritura, done_bus,
    input  start_bus, rw, Selec_Mux_DD, ocupado, fin_barrido, error_timeout
  );
endinterface

// File: rtl/contador_refresco.sv
// Free-running refresh counter; tick_c is high for the one cycle before it wraps to zero.
module contador_refresco #(
  parameter int unsigned REFRESH_TICKS = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_c
);

  localparam int unsigned    CNT_W  = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(REFRESH_TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_c = (cnt_q == ULTIMO);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/secuenciador_bloques_datos.sv
// Sequences Selec_Mux_DD through init/read/write sweeps, one start/done bus handshake per code.
module secuenciador_bloques_datos
  import secuenciador_pkg::*;
#(
  parameter int unsigned REFRESH_TICKS = 1000000,
  parameter int unsigned TIMEOUT       = 4095
) (
  input logic                          clk,
  input logic                          reset_n,
  secuenciador_bloques_datos_if.master bus
);

  localparam int unsigned ESP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  estado_e             estado_q, estado_d;
  barrido_e            barr_q, barr_d;
  logic [PASO_W-1:0]   paso_q, paso_d;
  logic [1:0]          grp_act_q, grp_act_d, grp_pend_q, grp_pend_d;
  logic                pend_init_q, pend_init_d, pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [ESP_W-1:0]    espera_q, espera_d;
  logic [COD_W-1:0]    sel_q, sel_d;
  logic                rw_q, rw_d, ocup_q, ocup_d, start_q, start_d;
  logic                fin_q, fin_d, err_q, err_d;

  logic                tick_c;
  logic                arranca;
  barrido_e            barr_nuevo;
  logic [1:0]          grp_nuevo;
  logic [PASO_W-1:0]   paso_sig;
  paso_t               paso_nuevo;

  contador_refresco #(.REFRESH_TICKS(REFRESH_TICKS)) u_refresco (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_c (tick_c)
  );

  always_comb begin
    estado_d    = estado_q;
    barr_d      = barr_q;
    paso_d      = paso_q;
    grp_act_d   = grp_act_q;
    grp_pend_d  = grp_pend_q;
    pend_init_d = pend_init_q;
    pend_wr_d   = pend_wr_q;
    pend_rd_d   = pend_rd_q;
    espera_d    = espera_q;
    sel_d       = sel_q;
    rw_d        = rw_q;
    ocup_d      = ocup_q;
    start_d     = 1'b0;
    fin_d       = 1'b0;
    err_d       = 1'b0;
    arranca     = 1'b0;
    barr_nuevo  = barr_q;
    grp_nuevo   = grp_act_q;
    paso_sig    = paso_q + PASO_W'(1);
    paso_nuevo  = codigo_paso(barr_q, grp_act_q, paso_sig);

    case (estado_q)
      IDLE: begin
        if (pend_init_q) begin
          arranca     = 1'b1;
          barr_nuevo  = BARR_INIT;
          pend_init_d = 1'b0;
        end else if (pend_wr_q) begin
          arranca    = 1'b1;
          barr_nuevo = BARR_ESCR;
          grp_nuevo  = grp_pend_q;
          pend_wr_d  = 1'b0;
        end else if (pend_rd_q) begin
          arranca    = 1'b1;
          barr_nuevo = BARR_LECT;
          pend_rd_d  = 1'b0;
        end
        if (arranca) begin
          paso_nuevo = codigo_paso(barr_nuevo, grp_nuevo, '0);
          estado_d   = EMITIR;
          barr_d     = barr_nuevo;
          grp_act_d  = grp_nuevo;
          paso_d     = '0;
          sel_d      = paso_nuevo.codigo;
          rw_d       = paso_nuevo.rw;
          ocup_d     = 1'b1;
        end
      end
      EMITIR: begin
        start_d  = 1'b1;
        espera_d = '0;
        estado_d = ESPERAR;
      end
      ESPERAR: begin
        // done wins over a timeout expiring on the same edge
        if (bus.done_bus) begin
          if (es_ultimo(barr_q, paso_q)) begin
            estado_d = IDLE;
            sel_d    = COD_IDLE;
            rw_d     = 1'b0;
            ocup_d   = 1'b0;
            fin_d    = 1'b1;
          end else begin
            paso_d   = paso_sig;
            sel_d    = paso_nuevo.codigo;
            estado_d = EMITIR;
          end
        end else if (espera_q == ESP_W'(TIMEOUT - 1)) begin
          estado_d = IDLE;
          sel_d    = COD_IDLE;
          rw_d     = 1'b0;
          ocup_d   = 1'b0;
          err_d    = 1'b1;
        end else begin
          espera_d = espera_q + ESP_W'(1);
        end
      end
      default: estado_d = IDLE;
    endcase

    // New requests are applied after the start-clear so a same-edge request is not lost
    if (bus.init_req) pend_init_d = 1'b1;
    if (bus.escribir_req && (bus.grupo_escritura != 2'b11)) begin
      pend_wr_d  = 1'b1;
      grp_pend_d = bus.grupo_escritura;
    end
    if (tick_c) pend_rd_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= IDLE;
      barr_q      <= BARR_INIT;
      paso_q      <= '0;
      grp_act_q   <= '0;
      grp_pend_q  <= '0;
      pend_init_q <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_rd_q   <= 1'b0;
      espera_q    <= '0;
      sel_q       <= COD_IDLE;
      rw_q        <= 1'b0;
      ocup_q      <= 1'b0;
      start_q     <= 1'b0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      barr_q      <= barr_d;
      paso_q      <= paso_d;
      grp_act_q   <= grp_act_d;
      grp_pend_q  <= grp_pend_d;
      pend_init_q <= pend_init_d;
      pend_wr_q   <= pend_wr_d;
      pend_rd_q   <= pend_rd_d;
      espera_q    <= espera_d;
      sel_q       <= sel_d;
      rw_q        <= rw_d;
      ocup_q      <= ocup_d;
      start_q     <= start_d;
      fin_q       <= fin_d;
      err_q       <= err_d;
    end
  end

  assign bus.start_bus     = start_q;
  assign bus.rw            = rw_q;
  assign bus.Selec_Mux_DD  = sel_q;
  assign bus.ocupado       = ocup_q;
  assign bus.fin_barrido   = fin_q;
  assign bus.error_timeout = err_q;

endmodule

// File: doc/secuenciador_bloques_datos.md
Name: secuenciador_bloques_datos

Overview:
Scheduler that drives the 4-bit Selec_Mux_DD code consumed by the data-block enable decoder. It steps the code through fixed sweeps: init, periodic RTC read, and user write of one group. For each step it performs one start/done handshake with the RTC bus-transaction block. Arbitrates between init, write and periodic-refresh requests.

Parameters:
REFRESH_TICKS, 1000000, clk cycles between automatic read sweeps (10 ms at 100 MHz)
TIMEOUT, 4095, max cycles waiting for done_bus before a sweep is aborted

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
init_req  in  1  single-cycle pulse: request init sweep
escribir_req  in  1  single-cycle pulse: request write sweep
grupo_escritura  in  2  group to write: 00 fecha, 01 hora, 10 crono, 11 ignored (request dropped)
done_bus  in  1  single-cycle pulse from bus block: current transaction complete
start_bus  out  1  single-cycle pulse: launch transaction for current code
rw  out  1  1 = write, 0 = read; valid while ocupado
Selec_Mux_DD  out  4  code to enable decoder / data mux
ocupado  out  1  high while a sweep is in progress
fin_barrido  out  1  single-cycle pulse when a sweep completes normally
error_timeout  out  1  single-cycle pulse when a sweep is aborted

Behaviour:
- Code map: 0 init, 1 MS, 2 transfer command, 3-5 fecha, 6-8 hora, 9-11 crono, 15 idle (all enables off).
- Sweeps:
  - INIT: codes 0,1,2 with rw=1.
  - READ: codes 3..11 ascending with rw=0.
  - WRITE: the group's three codes ascending, then code 2, with rw=1.
- Reset (async, reset_n=0): Selec_Mux_DD=4'hF, start_bus=0, rw=0, ocupado=0, fin_barrido=0, error_timeout=0. Pending flags are cleared. Refresh counter=0. State=IDLE.
- Pending flags:
  - init_req sets pend_init.
  - escribir_req with a valid group sets pend_wr and captures the group. A newer request overwrites the group if the earlier one has not started.
  - The refresh counter runs in every state and wraps at REFRESH_TICKS-1. On wrap it sets pend_rd; it has no effect if pend_rd is already set.
  - A flag is cleared in the cycle its sweep starts.
- Priority at IDLE: init > write > read. Requests arriving mid-sweep stay pending; a running sweep is never pre-empted.
- FSM:
  - IDLE: if any flag is pending, go to EMITIR, load the first code, set rw and ocupado.
  - EMITIR: one cycle with start_bus=1; then go to ESPERAR and clear the wait counter.
  - ESPERAR: Selec_Mux_DD and rw are held stable.
    - On done_bus, if the step is not last: load the next code and go to EMITIR.
    - On done_bus at the last step: go to IDLE with Selec=F, ocupado=0 and fin_barrido pulse.
    - If the wait counter reaches TIMEOUT without done_bus: go to IDLE with Selec=F, ocupado=0 and error_timeout pulse. The aborted sweep's flag stays cleared and is not retried.
- Latency: a request pulse sampled at edge t while IDLE gives start_bus=1 in the cycle after edge t+2. Back-to-back steps: done_bus at edge t gives the next start_bus in the cycle after edge t+1.
- done_bus outside ESPERAR is ignored. done_bus coincident with timeout counts as done.
- Selec_Mux_DD changes only on IDLE→EMITIR, ESPERAR→EMITIR or return to IDLE. It never glitches within a step.
- Assertion of reset_n mid-sweep returns all outputs to their reset values immediately. No partial sweep resumes.

Decomposition:
- Package secuenciador_pkg holds:
  - Code constants COD_INIT=0, COD_MS=1, COD_TRANSF=2, COD_FECHA0=3, COD_HORA0=6, COD_CRONO0=9, COD_IDLE=15.
  - Sweep-type enum {BARR_INIT, BARR_LECT, BARR_ESCR}.
  - FSM state enum {IDLE, EMITIR, ESPERAR}.
- Sub-module contador_refresco (parameter REFRESH_TICKS) produces a one-cycle tick on wrap.
- Step index and code generation stay in the top module.

Test Plan:
1. Reset, then hold reset_n=1 with no requests (REFRESH_TICKS large) → Selec=F, all outputs 0 for 100 cycles.
2. init_req pulse; bench returns done_bus 3 cycles after each start_bus → codes 0,1,2 with rw=1, 3 start_bus pulses, fin_barrido once, Selec=F after.
3. REFRESH_TICKS=50, no requests → a read sweep every 50 cycles: 9 start_bus pulses, codes 3..11 ascending, rw=0.
4. escribir_req with grupo=01 during a read sweep → read completes first; then codes 6,7,8,2 with rw=1. A refresh tick during the write runs a read sweep afterwards.
5. TIMEOUT=16, init_req, done_bus never asserted → error_timeout pulses 16 cycles after ESPERAR entry; Selec=F, ocupado=0; no further start_bus.
6. reset_n low for 1 cycle mid read sweep (code 7) → Selec=F and ocupado=0 immediately. A subsequent done_bus is ignored, and no step resumes.
